burst_sram_ctrl: RTL and testbench
==================================

# burst_sram_ctrl

Parametrised single-port SRAM with a burst engine. It generalises the fixed 16x8 burst SRAM in data width, depth and burst length. It adds INCR and WRAP address sequencing, a ready/busy handshake, per-beat read-valid and last flags, and a completion pulse. It serves as the on-chip scratch memory behind bus-side burst masters in the same subsystem.

## Interface
- DW, 8: data width in bits
- AW, 4: address width; depth = 2^AW words
- LW, 4: burst_len width; maximum burst is 2^LW-1 beats
- WRAP_BEATS, 4: WRAP window size; a power of two, at most 2^AW

- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cs  in  1  request strobe; accepted only when ready=1
- we  in  1  1 = write burst, 0 = read burst; sampled at accept
- burst_type  in  1  0 = INCR, 1 = WRAP; sampled at accept
- addr  in  AW  start address; sampled at accept
- burst_len  in  LW  beat count N; a value of 0 is treated as N=1
- data_in  in  DW  write data for the current beat
- ready  out  1  block is idle and can accept a request
- data_out  out  DW  registered read data
- rd_valid  out  1  data_out holds a read beat this cycle
- rd_last  out  1  this read beat is the final beat of the burst
- done  out  1  one-cycle pulse after the last beat of any burst

## Operation
- FSM has two states, IDLE and BURST. There is no separate read/write state; the latched we bit selects the direction.
- A request is accepted at edge T when cs=1, ready=1 and rst_n=1. At that edge the block:
  - latches we, burst_type, addr and N;
  - executes beat 0.
- If N=1, the FSM stays in IDLE. Otherwise it enters BURST with beat counter k=1.
- In BURST, beat k executes at edge T+k. The FSM returns to IDLE at the edge that executes beat N-1.
- Write beat k: mem[a_k] <= data_in, sampled at that beat's edge. The master must hold each beat's data in the cycle preceding its edge.
- Read beat k: data_out <= mem[a_k]. rd_valid=1 after that edge; rd_last=1 only for k=N-1.
- INCR addressing: a_k = (addr + k) mod 2^AW.
- WRAP addressing: the upper AW-log2(WRAP_BEATS) bits are held. The low log2(WRAP_BEATS) bits are (addr_low + k) mod WRAP_BEATS.
- WRAP with N > WRAP_BEATS keeps cycling inside the window. Later beats overwrite earlier ones.
- cs while ready=0 is ignored. Requests are not queued.
- Memory contents are not reset.

## Timing
- Reset values: ready=0 while rst_n=0. After reset releases:
  - ready=1 from the first cycle;
  - data_out=0, rd_valid=0, rd_last=0, done=0;
  - FSM in IDLE.
- ready is registered. It is 0 for cycles T+1 .. T+N-1 and 1 again from cycle T+N, so back-to-back bursts are accepted every N cycles.
- Read latency is 1 cycle: beat k data is visible in the cycle after edge T+k.
- done is high in the cycle after edge T+N-1, for both reads and writes.
- rd_valid and rd_last deassert in the first cycle with no read beat.
- Reset mid-burst aborts the burst:
  - beats already written remain;
  - no further writes occur;
  - all outputs return to their reset values at the reset edge.
- In IDLE, data_out holds the last read value; only rd_valid qualifies it.

## Structure
- Package burst_sram_pkg holds:
  - the state enum (IDLE, BURST);
  - the burst type constants BURST_INCR=0 and BURST_WRAP=1.
- One sub-module, burst_sram_array: a single-port synchronous-read array with parameters DW and AW, and ports clk, en, we, addr, wdata, rdata.
- The top level holds the FSM, beat counter, address generator and output flags.

## Test plan
- Single beat: write addr 3, N=1, data A5; then read addr 3, N=1 -> data_out=A5 with rd_valid=1, rd_last=1 one cycle after accept; done pulses after each burst.
- INCR with wrap-around: write addr 14, N=4, data 10,11,12,13 -> mem[14,15,0,1]. Read addr 14, N=4 -> 10,11,12,13 in 4 consecutive cycles, rd_last on the 4th only.
- WRAP: write addr 6, N=4, data 20..23 -> mem[6]=20, mem[7]=21, mem[4]=22, mem[5]=23. Read WRAP addr 4, N=4 -> 22,23,20,21.
- Busy rejection: write addr 0, N=8; during T+2 drive cs=1, we=1, addr 9, data FF -> mem[9] unchanged, ready=0 for T+1..T+7, next request accepted at T+8.
- burst_len=0: write addr 8, data E9 -> exactly one beat, mem[9] untouched, done one cycle later.
- Reset mid-burst: write addr 0, N=8, data 30..37; drive rst_n=0 after beat 2 -> mem[0..2]=30..32, mem[3..7] unchanged, ready=1 the cycle after rst_n returns high.

Source files
------------

// File: rtl/burst_sram_pkg.sv
// burst_sram_pkg
// Shared definitions for the burst SRAM controller:
//   state_t    - controller FSM states (IDLE, BURST)
//   BURST_INCR - linear address sequencing, wraps at the end of memory
//   BURST_WRAP - address sequencing confined to an aligned WRAP_BEATS window
package burst_sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic BURST_INCR = 1'b0;
    localparam logic BURST_WRAP = 1'b1;

endpackage

// File: rtl/burst_sram_array.sv
// burst_sram_array
// Single-port synchronous-read memory of 2^AW words of DW bits.
// Ports:
//   clk   in  clock
//   en    in  access enable for this edge
//   we    in  1 = write wdata to addr, 0 = read addr into rdata
//   addr  in  word address
//   wdata in  write data
//   rdata out registered read data; holds its value on writes and idle cycles
// Contents are never reset.
module burst_sram_array #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // The read register only changes on a read access, so the last read
    // word stays visible while the controller is idle or writing.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_sram_ctrl.sv
// burst_sram_ctrl
// Single-port SRAM with a burst engine supporting INCR and WRAP sequencing.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   cs         in  request strobe, accepted only while ready=1
//   we         in  1 = write burst, 0 = read burst (sampled at accept)
//   burst_type in  0 = INCR, 1 = WRAP (sampled at accept)
//   addr       in  start address (sampled at accept)
//   burst_len  in  beat count, 0 behaves as 1
//   data_in    in  write data for the beat executing at the next edge
//   ready      out idle and able to accept a request
//   data_out   out registered read data
//   rd_valid   out data_out carries a read beat this cycle
//   rd_last    out this read beat is the last of its burst
//   done       out one-cycle pulse after the final beat of any burst
// Beat 0 executes on the accepting edge itself, so a one-beat burst never
// leaves IDLE.
module burst_sram_ctrl
    import burst_sram_pkg::*;
#(
    parameter int DW         = 8,
    parameter int AW         = 4,
    parameter int LW         = 4,
    parameter int WRAP_BEATS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          we,
    input  logic          burst_type,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] burst_len,
    input  logic [DW-1:0] data_in,
    output logic          ready,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          done
);

    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [AW-1:0] WRAP_MASK = AW'(WRAP_BEATS - 1);

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic          we_q, we_d;
    logic          type_q, type_d;
    logic          ready_q, ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          done_q, done_d;
    logic          have_data_q, have_data_d;

    logic          accept;
    logic [LW-1:0] n_eff;
    logic          beat_active;
    logic          beat_we;
    logic          beat_type;
    logic [AW-1:0] beat_base;
    logic [LW-1:0] beat_cnt;
    logic          beat_last;
    logic [AW-1:0] addr_mask;
    logic [AW-1:0] beat_sum;
    logic [AW-1:0] beat_addr;
    logic          mem_en;
    logic [DW-1:0] mem_rdata;

    // Beat decode. In IDLE the beat (if any) comes straight from the request
    // pins; in BURST it comes from the latched request and the beat counter.
    // The address is built by masking: bits outside the mask are held from
    // the start address, bits inside it advance with the beat index. INCR
    // uses an all-ones mask, WRAP the window mask.
    always_comb begin
        accept    = cs && ready_q;
        n_eff     = (burst_len == '0) ? LEN_ONE : burst_len;
        beat_active = accept;
        beat_we   = we;
        beat_type = burst_type;
        beat_base = addr;
        beat_cnt  = '0;
        beat_last = (n_eff == LEN_ONE);
        if (state_q == BURST) begin
            beat_active = 1'b1;
            beat_we     = we_q;
            beat_type   = type_q;
            beat_base   = base_q;
            beat_cnt    = cnt_q;
            beat_last   = (cnt_q == len_q - LEN_ONE);
        end
        addr_mask = '1;
        case (beat_type)
            BURST_INCR: addr_mask = '1;
            BURST_WRAP: addr_mask = WRAP_MASK;
            default:    addr_mask = '1;
        endcase
        beat_sum  = beat_base + AW'(beat_cnt);
        beat_addr = (beat_base & ~addr_mask) | (beat_sum & addr_mask);
    end

    // Next-state logic. ready is registered and simply reflects whether the
    // FSM will sit in IDLE after this edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        base_d  = base_q;
        we_d    = we_q;
        type_d  = type_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d  = n_eff;
                    base_d = addr;
                    we_d   = we;
                    type_d = burst_type;
                    if (n_eff != LEN_ONE) begin
                        state_d = BURST;
                        cnt_d   = LEN_ONE;
                    end
                end
            end
            BURST: begin
                cnt_d = cnt_q + LEN_ONE;
                if (beat_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        rd_valid_d  = beat_active && !beat_we;
        rd_last_d   = rd_valid_d && beat_last;
        done_d      = beat_active && beat_last;
        have_data_d = have_data_q || rd_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            type_q      <= BURST_INCR;
            ready_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            have_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            we_q        <= we_d;
            type_q      <= type_d;
            ready_q     <= ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            have_data_q <= have_data_d;
        end
    end

    // The memory has no reset, so its enable is gated by rst_n to stop an
    // in-flight burst from touching the array on the reset edge.
    assign mem_en = beat_active && rst_n;

    burst_sram_array #(
        .DW(DW),
        .AW(AW)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .we   (beat_we),
        .addr (beat_addr),
        .wdata(data_in),
        .rdata(mem_rdata)
    );

    // The array's read register is not reset; data_out reads as zero until
    // the first read beat after reset has loaded it.
    assign data_out = have_data_q ? mem_rdata : '0;
    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_burst_sram_ctrl.sv
// tb_burst_sram_ctrl
// Directed bench for burst_sram_ctrl (DW=8, AW=4, LW=4, WRAP_BEATS=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_burst_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       we;
    logic       burst_type;
    logic [3:0] addr;
    logic [3:0] burst_len;
    logic [7:0] data_in;
    logic       ready;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       rd_last;
    logic       done;

    int errorCount = 0;
    int checkCount = 0;

    burst_sram_ctrl #(
        .DW(8),
        .AW(4),
        .LW(4),
        .WRAP_BEATS(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .we        (we),
        .burst_type(burst_type),
        .addr      (addr),
        .burst_len (burst_len),
        .data_in   (data_in),
        .ready     (ready),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .done      (done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's worth of request inputs.
    task automatic applyStimulus(input logic c, input logic w, input logic bt,
                                 input logic [3:0] a, input logic [3:0] n,
                                 input logic [7:0] d);
        cs         = c;
        we         = w;
        burst_type = bt;
        addr       = a;
        burst_len  = n;
        data_in    = d;
    endtask

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Write burst; beat k data is data[8k+7:8k]. Checks busy and completion.
    task automatic writeBurst(input logic bt, input logic [3:0] a, input int n,
                              input logic [63:0] data, input string tag);
        int beats;
        beats = (n == 0) ? 1 : n;
        applyStimulus(1'b1, 1'b1, bt, a, 4'(n), data[7:0]);
        step();
        for (int k = 1; k < beats; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, data[k*8 +: 8]);
            checkOutput({tag, " busy"}, 32'(ready), 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " ready"}, 32'(ready), 32'd1);
        checkOutput({tag, " no rd_valid"}, 32'(rd_valid), 32'd0);
        step();
        checkOutput({tag, " done drop"}, 32'(done), 32'd0);
    endtask

    // Read burst; expected beat k data is expData[8k+7:8k].
    task automatic readBurst(input logic bt, input logic [3:0] a, input int n,
                             input logic [63:0] expData, input string tag);
        int beats;
        beats = (n == 0) ? 1 : n;
        applyStimulus(1'b1, 1'b0, bt, a, 4'(n), 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
        for (int k = 0; k < beats; k++) begin
            if (k > 0) step();
            checkOutput($sformatf("%s data%0d", tag, k), 32'(data_out), 32'(expData[k*8 +: 8]));
            checkOutput($sformatf("%s valid%0d", tag, k), 32'(rd_valid), 32'd1);
            checkOutput($sformatf("%s last%0d", tag, k), 32'(rd_last), 32'(k == beats - 1));
            checkOutput($sformatf("%s done%0d", tag, k), 32'(done), 32'(k == beats - 1));
        end
        step();
        checkOutput({tag, " valid drop"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, " last drop"}, 32'(rd_last), 32'd0);
        checkOutput({tag, " done drop"}, 32'(done), 32'd0);
        checkOutput({tag, " ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
        step();
        step();
        checkOutput("rst ready", 32'(ready), 32'd0);
        checkOutput("rst rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("post-rst ready", 32'(ready), 32'd1);
        checkOutput("post-rst data_out", 32'(data_out), 32'd0);
        checkOutput("post-rst rd_last", 32'(rd_last), 32'd0);

        // Single beat.
        writeBurst(1'b0, 4'd3, 1, 64'hA5, "single wr");
        readBurst(1'b0, 4'd3, 1, 64'hA5, "single rd");

        // INCR across the top of memory: 14,15,0,1.
        writeBurst(1'b0, 4'd14, 4, 64'h13121110, "incr wr");
        readBurst(1'b0, 4'd14, 4, 64'h13121110, "incr rd");

        // WRAP: start 6 -> 6,7,4,5; read from 4 -> 4,5,6,7.
        writeBurst(1'b1, 4'd6, 4, 64'h23222120, "wrap wr");
        readBurst(1'b1, 4'd4, 4, 64'h21202322, "wrap rd");

        // Busy rejection: intruding write to 9 must be ignored.
        writeBurst(1'b0, 4'd9, 1, 64'h99, "pre9 wr");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 8'h40);
        step();
        for (int k = 1; k < 8; k++) begin
            if (k == 2) applyStimulus(1'b1, 1'b1, 1'b0, 4'd9, 4'd1, 8'hFF);
            else        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'(8'h40 + k));
            checkOutput($sformatf("busy ready T+%0d", k), 32'(ready), 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        checkOutput("busy ready T+8", 32'(ready), 32'd1);
        checkOutput("busy done", 32'(done), 32'd1);
        readBurst(1'b0, 4'd9, 1, 64'h99, "busy rd9");

        // burst_len=0 behaves as one beat; mem[9] must keep 99.
        writeBurst(1'b0, 4'd8, 0, 64'hE9, "len0 wr");
        readBurst(1'b0, 4'd8, 2, 64'h99E9, "len0 rd");

        // Reset mid-burst.
        writeBurst(1'b0, 4'd3, 5, 64'h5453525150, "pre3 wr");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 8'h30);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h31);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h32);
        step();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h33);
        step();
        checkOutput("midrst ready", 32'(ready), 32'd0);
        checkOutput("midrst rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("midrst rd_last", 32'(rd_last), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst data_out", 32'(data_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h34);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("midrst ready after", 32'(ready), 32'd1);
        readBurst(1'b0, 4'd0, 8, 64'h5453525150323130, "midrst rd");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
